idct_transpose_buf: RTL and testbench

IDCT_TRANSPOSE_BUF -- requirements
Module: idct_transpose_buf

---
 rtl/idct_transpose_buf.sv | 109 ++++++++++
 tb/tb_idct_transpose_buf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/idct_transpose_buf.sv
// Ping-pong 4x4 transpose buffer between the row and column IDCT passes.
// Samples arrive row-major, one per cycle; columns leave four samples wide.
module idct_transpose_buf #(
  parameter int unsigned WIDTH = 25
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] d_in,
  output logic                    in_ready,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] d_out_1,
  output logic signed [WIDTH-1:0] d_out_2,
  output logic signed [WIDTH-1:0] d_out_3,
  output logic signed [WIDTH-1:0] d_out_4,
  output logic                    ovf
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned COL_W = 2;
  localparam int unsigned DIM   = 4;

  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [1:0]       full_q, full_d;
  logic             ovf_q, ovf_d;
  logic             wr_en, rd_en;

  logic signed [WIDTH-1:0] bank_q [2][DIM][DIM];

  assign in_ready  = ~full_q[wr_sel_q];
  assign out_valid = full_q[rd_sel_q];
  assign ovf       = ovf_q;
  assign wr_en     = in_valid & in_ready;
  assign rd_en     = out_valid & out_ready;

  // Write and read sides touch different banks whenever both fire, so the
  // full-flag updates never collide.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    col_d    = col_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    full_d   = full_q;
    ovf_d    = ovf_q;

    if (in_valid && !in_ready) begin
      ovf_d = 1'b1;
    end

    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
      if (wr_cnt_q == CNT_W'(15)) begin
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = ~wr_sel_q;
      end
    end

    if (rd_en) begin
      col_d = col_q + COL_W'(1);
      if (col_q == COL_W'(3)) begin
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = ~rd_sel_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_cnt_q <= '0;
      col_q    <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      full_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      col_q    <= col_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  // Data banks carry no reset; stale contents are masked by the full flags.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank_q[wr_sel_q][wr_cnt_q[3:2]][wr_cnt_q[1:0]] <= d_in;
    end
  end

  always_comb begin
    d_out_1 = '0;
    d_out_2 = '0;
    d_out_3 = '0;
    d_out_4 = '0;
    if (out_valid) begin
      d_out_1 = bank_q[rd_sel_q][0][col_q];
      d_out_2 = bank_q[rd_sel_q][1][col_q];
      d_out_3 = bank_q[rd_sel_q][2][col_q];
      d_out_4 = bank_q[rd_sel_q][3][col_q];
    end
  end

endmodule

// File: tb/tb_idct_transpose_buf.sv
// Scoreboard bench for idct_transpose_buf: blocks are transposed in the bench
// as they are driven and columns are compared as the DUT hands them off.
module tb_idct_transpose_buf;

  localparam int unsigned W = 25;

  typedef struct packed {
    logic signed [W-1:0] r0;
    logic signed [W-1:0] r1;
    logic signed [W-1:0] r2;
    logic signed [W-1:0] r3;
  } col_t;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                in_valid = 1'b0;
  logic signed [W-1:0] d_in = '0;
  logic                in_ready;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic signed [W-1:0] d_out_1, d_out_2, d_out_3, d_out_4;
  logic                ovf;

  int   n_checks = 0;
  int   n_errors = 0;
  col_t sb_q[$];
  logic signed [W-1:0] blk [16];
  int   blk_n = 0;

  idct_transpose_buf #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .d_in     (d_in),
    .in_ready (in_ready),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .d_out_1  (d_out_1),
    .d_out_2  (d_out_2),
    .d_out_3  (d_out_3),
    .d_out_4  (d_out_4),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Columns presented with out_ready=1 at the falling edge are consumed on
  // the next rising edge.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_column", 64'(1), 64'(0));
      end else begin
        check("col_r0", d_out_1, sb_q[0].r0);
        check("col_r1", d_out_2, sb_q[0].r1);
        check("col_r2", d_out_3, sb_q[0].r2);
        check("col_r3", d_out_4, sb_q[0].r3);
        void'(sb_q.pop_front());
      end
    end
  end

  // Drive one sample for one edge; exp_acc is what the scenario expects of in_ready.
  task automatic put(input logic signed [W-1:0] v, input logic exp_acc);
    in_valid = 1'b1;
    d_in     = v;
    #1;
    if (in_ready !== exp_acc) check("in_ready", in_ready, exp_acc);
    if (exp_acc) begin
      blk[blk_n] = v;
      blk_n++;
      if (blk_n == 16) begin
        for (int c = 0; c < 4; c++)
          sb_q.push_back('{blk[c], blk[4+c], blk[8+c], blk[12+c]});
        blk_n = 0;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    sb_q.delete();
    blk_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ovf", ovf, 1'b0);
    check("rst_d_out", {d_out_1, d_out_2, d_out_3, d_out_4}, 64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
    #1;
    check({tag, "_pending"}, 64'(sb_q.size()), 64'(0));
    check({tag, "_valid_low"}, out_valid, 1'b0);
  endtask

  initial begin
    #3;
    do_reset();

    // Basic transpose of 0..15 with the column stage always ready.
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) put(W'(k), 1'b1);
    check("basic_valid_before", out_valid, 1'b0);
    put(W'(15), 1'b1);
    check("basic_valid_after", out_valid, 1'b1);
    check("basic_col0_r1", d_out_2, 64'(4));
    drain("basic");

    // Two blocks fill both banks; a third offer overflows.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 32; k++) put(W'(1000 + 7 * k), 1'b1);
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_ovf_clear", ovf, 1'b0);
    put(W'(-5), 1'b0);
    check("bp_ovf_set", ovf, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_r0", d_out_1, sb_q[0].r0);
    check("bp_hold_r3", d_out_4, sb_q[0].r3);
    out_ready = 1'b1;
    drain("bp");
    check("bp_ovf_sticky", ovf, 1'b1);

    // Streaming four blocks with extreme values mixed in.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 64; k++) begin
      logic signed [W-1:0] v;
      v = W'($urandom);
      if (k == 5)  v = -W'(16777216);
      if (k == 22) v = W'(16777215);
      if (k == 40) v = -W'(16777216);
      if (k == 63) v = W'(16777215);
      put(v, 1'b1);
    end
    drain("stream");
    check("stream_ovf", ovf, 1'b0);

    // Reset partway through a block discards it.
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) put(W'(50 + k), 1'b1);
    do_reset();
    for (int k = 0; k < 16; k++) put(W'(100 + k), 1'b1);
    check("midrst_col0_r0", d_out_1, 64'(100));
    check("midrst_col0_r3", d_out_4, 64'(112));
    drain("midrst");

    // Last read of block 1 and last write of block 2 on the same edge.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++) put(W'(200 + k), 1'b1);
    for (int k = 0; k < 12; k++) put(W'(300 + k), 1'b1);
    out_ready = 1'b1;
    for (int k = 12; k < 16; k++) put(W'(300 + k), 1'b1);
    check("simul_valid", out_valid, 1'b1);
    check("simul_col0_r0", d_out_1, 64'(300));
    check("simul_col0_r2", d_out_3, 64'(308));
    check("simul_pending", 64'(sb_q.size()), 64'(4));
    drain("simul");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
